// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single write port of the async FIFO
// between NUM_REQ requesters in the write clock domain. One requester owns
// the port for a burst. Its words are forwarded to the FIFO write port only
// while the FIFO is not full. The grant is released on the last word of a
// packet, when MAX_BURST words have been written, or when the requester
// withdraws its request.
//
// Ports:
//   wr_clk_i    in   1                   write-domain clock
//   rst_n_i     in   1                   asynchronous active-low reset
//   req_i       in   NUM_REQ             per-requester request (word presented)
//   req_data_i  in   NUM_REQ*FIFO_WIDTH  packed words, requester k at [k*W +: W]
//   req_last_i  in   NUM_REQ             presented word is the last of its packet
//   full_i      in   1                   FIFO full flag (write domain)
//   ack_o       out  NUM_REQ             one-hot, word of requester k accepted
//   grant_o     out  NUM_REQ             one-hot registered grant
//   wr_en_o     out  1                   FIFO write enable
//   wr_data_o   out  FIFO_WIDTH          FIFO write data
//   busy_o      out  1                   a grant is active
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int DLY        = 1
) (
  input  logic                          wr_clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic                          full_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          wr_en_o,
  output logic [FIFO_WIDTH-1:0]         wr_data_o,
  output logic                          busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // DLY is kept so this block drops into benches that pass it to every
  // register stage; the flops here are zero-delay, so only its range is
  // checked at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be in 1..255");
  end
  if (FIFO_WIDTH < 1) begin : g_bad_width
    $error("fifo_wr_arbiter: FIFO_WIDTH must be at least 1");
  end
  if (DLY < 0) begin : g_bad_dly
    $error("fifo_wr_arbiter: DLY must not be negative");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                 state_q,    state_d;
  logic [NUM_REQ-1:0]     grant_q,    grant_d;
  logic [PTR_W-1:0]       gnt_idx_q,  gnt_idx_d;
  logic [PTR_W-1:0]       rr_ptr_q,   rr_ptr_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;

  logic                   found;
  logic [PTR_W-1:0]       winner;
  logic [PTR_W-1:0]       cand;
  logic                   cur_req;
  logic                   cur_last;
  logic [FIFO_WIDTH-1:0]  cur_data;
  logic                   beat_hit_max;
  logic                   accept;

  logic [FIFO_WIDTH-1:0]  req_word [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_word[k] = req_data_i[k*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // Round-robin search: the first requester at or above rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Datapath for the granted requester. A write only happens in BURST and
  // never while the FIFO reports full, so the FIFO cannot overflow.
  always_comb begin
    cur_req      = req_i[gnt_idx_q];
    cur_last     = req_last_i[gnt_idx_q];
    cur_data     = req_word[gnt_idx_q];
    accept       = (state_q == BURST) && cur_req && !full_i;
    beat_hit_max = (({1'b0, beat_cnt_q} + 9'd1) == 9'(MAX_BURST));
  end

  assign wr_en_o   = accept;
  assign ack_o     = accept ? grant_q : '0;
  assign wr_data_o = accept ? cur_data : '0;
  assign grant_o   = grant_q;
  assign busy_o    = (state_q == BURST);

  // Next-state logic. A withdrawn request, a last word, or the final beat of
  // a burst all funnel into one release path, so a word that is both last and
  // at the burst limit causes exactly one release.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BURST;
          grant_d    = NUM_REQ'(1) << winner;
          gnt_idx_d  = winner;
          rr_ptr_d   = PTR_W'((int'(winner) + 1) % NUM_REQ);
          beat_cnt_d = '0;
        end
      end

      BURST: begin
        if (!cur_req || (accept && (cur_last || beat_hit_max))) begin
          state_d    = IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset drops any grant immediately.
  always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, FIFO_WIDTH=8,
// MAX_BURST=4). Each requester is a small source model that presents words
// from a table and advances on ack. Expected FIFO writes are queued when a
// scenario loads its sources and popped by the write monitor.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;

  logic            wr_clk_i = 1'b0;
  logic            rst_n_i  = 1'b0;
  logic [NR-1:0]   req_i    = '0;
  logic [NR*W-1:0] req_data_i = '0;
  logic [NR-1:0]   req_last_i = '0;
  logic            full_i   = 1'b0;
  logic [NR-1:0]   ack_o;
  logic [NR-1:0]   grant_o;
  logic            wr_en_o;
  logic [W-1:0]    wr_data_o;
  logic            busy_o;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .FIFO_WIDTH (W),
    .MAX_BURST  (4),
    .DLY        (1)
  ) dut (
    .wr_clk_i   (wr_clk_i),
    .rst_n_i    (rst_n_i),
    .req_i      (req_i),
    .req_data_i (req_data_i),
    .req_last_i (req_last_i),
    .full_i     (full_i),
    .ack_o      (ack_o),
    .grant_o    (grant_o),
    .wr_en_o    (wr_en_o),
    .wr_data_o  (wr_data_o),
    .busy_o     (busy_o)
  );

  always #5 wr_clk_i = ~wr_clk_i;

  int total = 0;
  int bad   = 0;
  int write_count = 0;

  logic [W-1:0]  src_data [NR][8];
  int            src_len  [NR];
  int            src_pos  [NR];
  bit            src_en   [NR];
  bit            src_last [NR];
  logic [NR-1:0] ack_seen = '0;

  logic [W-1:0]  exp_q [$];
  logic [NR-1:0] grant_log [$];
  logic [NR-1:0] last_grant = '0;

  // Write monitor / scoreboard, sampled on the falling edge.
  always @(negedge wr_clk_i) begin
    logic [W-1:0] exp_word;
    ack_seen = ack_o;
    if (full_i === 1'b1) begin
      total++;
      if (wr_en_o !== 1'b0) begin
        bad++;
        $display("[TB] FAIL no_write_when_full: wr_en_o=%b required 0", wr_en_o);
      end
    end
    if (wr_en_o === 1'b1) begin
      write_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_write: data=%h, none expected", wr_data_o);
      end else begin
        exp_word = exp_q.pop_front();
        if (wr_data_o !== exp_word) begin
          bad++;
          $display("[TB] FAIL write_data: got %h required %h", wr_data_o, exp_word);
        end
      end
    end
    if (grant_o !== last_grant) begin
      if (grant_o !== '0) grant_log.push_back(grant_o);
      last_grant = grant_o;
    end
  end

  task automatic drive_reqs();
    for (int k = 0; k < NR; k++) begin
      if (src_en[k] && src_pos[k] < src_len[k]) begin
        req_i[k]             = 1'b1;
        req_data_i[k*W +: W] = src_data[k][src_pos[k]];
        req_last_i[k]        = src_last[k] && (src_pos[k] == src_len[k] - 1);
      end else begin
        req_i[k]             = 1'b0;
        req_data_i[k*W +: W] = '0;
        req_last_i[k]        = 1'b0;
      end
    end
  endtask

  // One clock: consume acked words after the edge, then present the next.
  task automatic tick();
    @(posedge wr_clk_i);
    #1;
    for (int k = 0; k < NR; k++) if (ack_seen[k]) src_pos[k]++;
    ack_seen = '0;
    drive_reqs();
    #1;
  endtask

  task automatic load_src(input int k, input int n, input bit use_last, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      src_data[k][i] = base + W'(i);
      exp_q.push_back(base + W'(i));
    end
    src_len[k]  = n;
    src_pos[k]  = 0;
    src_last[k] = use_last;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    full_i  = 1'b0;
    for (int k = 0; k < NR; k++) begin
      src_en[k] = 1'b0; src_pos[k] = 0; src_len[k] = 0; src_last[k] = 1'b0;
    end
    ack_seen = '0;
    exp_q.delete();
    grant_log.delete();
    drive_reqs();
    repeat (2) @(posedge wr_clk_i);
    #2 rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    req_i = 4'b1111; req_data_i = 32'hDEADBEEF; req_last_i = 4'b1111;
    repeat (2) @(posedge wr_clk_i);
    #2;
    total++; if (grant_o !== 4'b0000) begin bad++; $display("[TB] FAIL reset_grant: got %b required 0000", grant_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b required 0", busy_o); end
    total++; if (wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_en: got %b required 0", wr_en_o); end
    total++; if (ack_o !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ack: got %b required 0000", ack_o); end
    total++; if (wr_data_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_wr_data: got %h required 00", wr_data_o); end
    do_reset();
  endtask

  task automatic test_single_packet();
    int wc0;
    do_reset();
    load_src(2, 3, 1'b1, 8'hA1);
    wc0 = write_count;
    src_en[2] = 1'b1;
    tick();
    total++; if (grant_o !== 4'b0000 || wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL sp_idle_bubble: grant=%b wr_en=%b required 0000/0", grant_o, wr_en_o); end
    tick();
    total++; if (grant_o !== 4'b0100) begin bad++; $display("[TB] FAIL sp_grant: got %b required 0100", grant_o); end
    total++; if (ack_o !== 4'b0100 || wr_data_o !== 8'hA1) begin bad++; $display("[TB] FAIL sp_beat1: ack=%b data=%h required 0100/a1", ack_o, wr_data_o); end
    tick();
    total++; if (wr_en_o !== 1'b1 || wr_data_o !== 8'hA2) begin bad++; $display("[TB] FAIL sp_beat2: wr_en=%b data=%h required 1/a2", wr_en_o, wr_data_o); end
    tick();
    total++; if (wr_en_o !== 1'b1 || wr_data_o !== 8'hA3) begin bad++; $display("[TB] FAIL sp_beat3: wr_en=%b data=%h required 1/a3", wr_en_o, wr_data_o); end
    tick();
    total++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL sp_release: grant=%b busy=%b required 0000/0", grant_o, busy_o); end
    total++; if (write_count - wc0 != 3) begin bad++; $display("[TB] FAIL sp_write_count: got %0d required 3", write_count - wc0); end
    // rr_ptr is now 3, so requester 3 must beat requester 0.
    load_src(3, 1, 1'b1, 8'hB3);
    load_src(0, 1, 1'b1, 8'hB0);
    src_en[0] = 1'b1; src_en[3] = 1'b1;
    tick();
    tick();
    total++; if (grant_o !== 4'b1000) begin bad++; $display("[TB] FAIL sp_rr_ptr: grant=%b required 1000", grant_o); end
    tick();
    tick();
    total++; if (grant_o !== 4'b0001) begin bad++; $display("[TB] FAIL sp_rr_next: grant=%b required 0001", grant_o); end
    tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL sp_drain: %0d words left, required 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    int wc0;
    logic [NR-1:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    do_reset();
    for (int k = 0; k < NR; k++) begin
      for (int i = 0; i < 8; i++) src_data[k][i] = 8'h40 + W'(k*16 + i);
      src_len[k] = 8; src_last[k] = 1'b0; src_en[k] = 1'b1;
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h40 + W'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h50 + W'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h60 + W'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h70 + W'(i));
    for (int i = 4; i < 8; i++) exp_q.push_back(8'h40 + W'(i));
    wc0 = write_count;
    tick();
    repeat (25) tick();
    for (int k = 0; k < NR; k++) src_en[k] = 1'b0;
    drive_reqs();
    total++; if (write_count - wc0 != 20) begin bad++; $display("[TB] FAIL rr_throughput: %0d writes required 20", write_count - wc0); end
    total++; if (grant_log.size() != 5) begin bad++; $display("[TB] FAIL rr_grant_count: got %0d required 5", grant_log.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) begin
        total++;
        if (grant_log[i] !== exp_g[i]) begin bad++; $display("[TB] FAIL rr_grant_order[%0d]: got %b required %b", i, grant_log[i], exp_g[i]); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL rr_drain: %0d words left, required 0", exp_q.size()); end
  endtask

  task automatic test_full_stall();
    int wc0;
    do_reset();
    load_src(1, 4, 1'b1, 8'h10);
    wc0 = write_count;
    src_en[1] = 1'b1;
    tick();
    tick();
    total++; if (grant_o !== 4'b0010 || wr_data_o !== 8'h10) begin bad++; $display("[TB] FAIL fs_first: grant=%b data=%h required 0010/10", grant_o, wr_data_o); end
    tick();
    tick();
    full_i = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (wr_en_o !== 1'b0 || ack_o !== 4'b0000 || wr_data_o !== 8'h00 || grant_o !== 4'b0010) begin
        bad++;
        $display("[TB] FAIL fs_stall[%0d]: wr_en=%b ack=%b data=%h grant=%b required 0/0000/00/0010", c, wr_en_o, ack_o, wr_data_o, grant_o);
      end
      if (c < 2) tick();
    end
    tick();
    full_i = 1'b0;
    #1;
    total++; if (wr_en_o !== 1'b1 || wr_data_o !== 8'h12) begin bad++; $display("[TB] FAIL fs_resume: wr_en=%b data=%h required 1/12", wr_en_o, wr_data_o); end
    tick();
    tick();
    total++; if (grant_o !== 4'b0000) begin bad++; $display("[TB] FAIL fs_release: grant=%b required 0000", grant_o); end
    total++; if (write_count - wc0 != 4 || exp_q.size() != 0) begin bad++; $display("[TB] FAIL fs_words: writes=%0d left=%0d required 4/0", write_count - wc0, exp_q.size()); end
  endtask

  task automatic test_req_drop();
    int wc0;
    do_reset();
    load_src(2, 2, 1'b0, 8'h20);
    load_src(3, 1, 1'b1, 8'h30);
    wc0 = write_count;
    src_en[2] = 1'b1; src_en[3] = 1'b1;
    tick();
    tick();
    total++; if (grant_o !== 4'b0100) begin bad++; $display("[TB] FAIL rd_grant: got %b required 0100", grant_o); end
    tick();
    tick();
    total++; if (grant_o !== 4'b0100 || wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_withdraw: grant=%b wr_en=%b required 0100/0", grant_o, wr_en_o); end
    tick();
    total++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_release: grant=%b busy=%b required 0000/0", grant_o, busy_o); end
    tick();
    total++; if (grant_o !== 4'b1000 || wr_data_o !== 8'h30) begin bad++; $display("[TB] FAIL rd_next: grant=%b data=%h required 1000/30", grant_o, wr_data_o); end
    tick();
    total++; if (write_count - wc0 != 3 || exp_q.size() != 0) begin bad++; $display("[TB] FAIL rd_words: writes=%0d left=%0d required 3/0", write_count - wc0, exp_q.size()); end
  endtask

  task automatic test_last_at_max();
    int wc0;
    do_reset();
    load_src(0, 4, 1'b1, 8'h50);
    load_src(1, 1, 1'b1, 8'h60);
    wc0 = write_count;
    src_en[0] = 1'b1; src_en[1] = 1'b1;
    tick();
    repeat (4) tick();
    total++; if (req_last_i[0] !== 1'b1 || wr_data_o !== 8'h53) begin bad++; $display("[TB] FAIL lm_last_beat: last=%b data=%h required 1/53", req_last_i[0], wr_data_o); end
    tick();
    total++; if (grant_o !== 4'b0000 || write_count - wc0 != 4) begin bad++; $display("[TB] FAIL lm_release: grant=%b writes=%0d required 0000/4", grant_o, write_count - wc0); end
    tick();
    total++; if (grant_o !== 4'b0010 || wr_data_o !== 8'h60) begin bad++; $display("[TB] FAIL lm_next: grant=%b data=%h required 0010/60", grant_o, wr_data_o); end
    tick();
    total++; if (grant_log.size() != 2) begin bad++; $display("[TB] FAIL lm_grants: got %0d grants required 2", grant_log.size()); end
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL lm_drain: %0d words left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 4; i++) src_data[2][i] = 8'h70 + W'(i);
    exp_q.push_back(8'h70);
    exp_q.push_back(8'h71);
    src_len[2] = 4; src_last[2] = 1'b1; src_en[2] = 1'b1;
    tick();
    tick();
    tick();
    tick();
    rst_n_i = 1'b0;
    src_en[2] = 1'b0;
    src_data[0][0] = 8'h80; src_len[0] = 1; src_last[0] = 1'b1; src_en[0] = 1'b1;
    src_data[1][0] = 8'h90; src_len[1] = 1; src_last[1] = 1'b1; src_en[1] = 1'b1;
    drive_reqs();
    #1;
    total++; if (grant_o !== 4'b0000 || busy_o !== 1'b0 || wr_en_o !== 1'b0 || ack_o !== 4'b0000 || wr_data_o !== 8'h00) begin bad++; $display("[TB] FAIL rm_async_drop: grant=%b busy=%b wr_en=%b ack=%b data=%h required all 0", grant_o, busy_o, wr_en_o, ack_o, wr_data_o); end
    tick();
    tick();
    total++; if (grant_o !== 4'b0000 || wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL rm_held: grant=%b wr_en=%b required 0000/0", grant_o, wr_en_o); end
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h90);
    rst_n_i = 1'b1;
    tick();
    total++; if (grant_o !== 4'b0001 || wr_data_o !== 8'h80) begin bad++; $display("[TB] FAIL rm_first_grant: grant=%b data=%h required 0001/80", grant_o, wr_data_o); end
    tick();
    tick();
    total++; if (grant_o !== 4'b0010) begin bad++; $display("[TB] FAIL rm_second_grant: grant=%b required 0010", grant_o); end
    tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL rm_drain: %0d words left, required 0", exp_q.size()); end
  endtask

  initial begin
    $display("[TB] starting fifo_wr_arbiter bench");
    test_reset();
    test_single_packet();
    test_round_robin();
    test_full_stall();
    test_req_drop();
    test_last_at_max();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
